// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry, LSB-first, WIDTH cycles per add.
// Optional SERIAL_ADDER_SUB_EN adds a sub input that turns the operation into a - b.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Valid/ready: a transfer happens on any rising edge where valid and ready are both 1;
   // once out_valid is raised, sum/cout stay frozen until that transfer.
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             carry;
   logic [5:0]       cnt;
   logic             bit_s, carry_next, last_bit;
   logic [WIDTH-1:0] b_load;
   logic             c_load;

   always_comb begin
      bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
      carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
      last_bit   = (cnt == CNT_LAST);
   end

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction is a + ~b + 1, so the carry register seeds the +1.
   always_comb begin
      b_load = sub ? ~b : b;
      c_load = sub ? 1'b1 : cin;
   end
`else
   always_comb begin
      b_load = b;
      c_load = cin;
   end
`endif

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b_load;
                  carry <= c_load;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= carry_next;
               sum   <= {bit_s, sum[WIDTH-1:1]};
               cnt   <= cnt + 6'd1;
               if (last_bit) cout <= carry_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes arithmetic expectations, negedge monitor pops and compares.
// Build with SERIAL_ADDER_SUB_EN defined to exercise subtraction as well.
module tb_serial_adder;
   localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic         clk, rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
   logic [W-1:0] a, b, sum;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub;
`endif

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_accept = 0;
   logic [W:0] exp_q[$];
   int         lat_q[$];
   logic       prev_valid = 1'b0;
   logic       prev_hold = 1'b0;
   logic [W:0] held = '0;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model: plain integer arithmetic
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci, input logic s);
      logic [W-1:0] d;
      if (s && HAS_SUB) begin
         d = x - y;
         return {x >= y, d};
      end
      return (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // driver tasks: called just after a rising edge, return just after one
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic s, input bit keep);
      int n = 0;
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
      sub = s;
`endif
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept", {31'd0, in_ready}, 32'd1);
      if (in_ready) begin
         exp_q.push_back(model(x, y, ci, s));
         lat_q.push_back(cyc + 1);
         last_accept = cyc + 1;
      end
      @(posedge clk);
      #1;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", exp_q.size(), 0);
   endtask

   // monitor
   always @(negedge clk) begin
      if (rst) begin
         prev_hold  = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {23'd0, cout, sum}, {23'd0, held});
         end
         if (out_valid) begin
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            if (!prev_valid && lat_q.size() != 0) begin
               int k;
               k = lat_q.pop_front();
               check("latency", cyc, k + W);
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
               logic [W:0] e;
               e = exp_q.pop_front();
               check("result", {23'd0, cout, sum}, {23'd0, e});
            end
         end
         prev_hold  = out_valid && !out_ready;
         held       = {cout, sum};
         prev_valid = out_valid;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      int k1, n;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result", {23'd0, cout, sum}, 32'd0);
      @(posedge clk); #1;

      // directed adds
      send(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0); drain();
      send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0); drain();
      send(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0); drain();
      send(8'h00, 8'h00, 1'b0, 1'b0, 1'b0); drain();

      // backpressure with an ignored in_valid while DONE waits
      out_ready = 1'b0;
      send(8'h22, 8'h33, 1'b0, 1'b0, 1'b0);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b1; a = 8'h11; b = 8'h00; cin = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
      check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
      check("bp_idle_holds", {23'd0, cout, sum}, 32'h055);
      repeat (20) @(posedge clk);
      #1;

      // back-to-back with in_valid and out_ready held high
      send(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
      k1 = last_accept;
      send(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
      check("b2b_interval", last_accept - k1, W + 2);
      drain();

      // reset three cycles into RUN
      send(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      lat_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", {23'd0, cout, sum}, 32'd0);
      @(posedge clk); #1;
      send(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0); drain();

      if (HAS_SUB) begin
         send(8'h10, 8'h01, 1'b0, 1'b1, 1'b0); drain();
         send(8'h00, 8'h01, 1'b0, 1'b1, 1'b0); drain();
         send(8'h10, 8'h01, 1'b1, 1'b0, 1'b0); drain();
      end

      // randomized operands, carry-in, mode and idle gaps
      for (int i = 0; i < 40; i++) begin
         send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), HAS_SUB && ($urandom_range(0, 1) == 1), 1'b0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
